// File: rtl/peg_bmtx_pkg.sv
// Shared widths, multiplier latency and the result record for the PEG B-matrix multiplier stream.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package peg_bmtx_pkg;
  localparam int A_W     = 16;
  localparam int B_W     = 14;
  localparam int P_W     = A_W + B_W;
  localparam int TAG_W   = 8;
  localparam int MUL_LAT = 3;

  typedef struct packed {
    logic signed [P_W-1:0] p;
    logic [TAG_W-1:0]      tag;
  } mul_res_t;
endpackage

// File: rtl/peg_bmtx_mul_mul_16s_14ns_30_4_1.sv
// Pipelined 16-bit signed x 14-bit unsigned multiplier with clock enable.
// Latency: 3 register stages (input regs, product reg, output reg).
// Backpressure: none; ce freezes every stage together.
module peg_bmtx_mul_mul_16s_14ns_30_4_1 #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 4,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 14,
  parameter int dout_WIDTH = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);
  logic [din0_WIDTH-1:0] a_reg;
  logic [din1_WIDTH-1:0] b_reg;
  logic [dout_WIDTH-1:0] a_ext;
  logic [dout_WIDTH-1:0] b_ext;
  logic [dout_WIDTH-1:0] p_reg0;
  logic [dout_WIDTH-1:0] p_reg1;

  // Sign-extend A and zero-extend B so a modulo-2^30 multiply yields the signed product.
  always_comb begin
    a_ext = {{(dout_WIDTH-din0_WIDTH){a_reg[din0_WIDTH-1]}}, a_reg};
    b_ext = {{(dout_WIDTH-din1_WIDTH){1'b0}}, b_reg};
  end

  // Operand capture, multiply and output buffering, all advanced by ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      p_reg0 <= '0;
      p_reg1 <= '0;
    end else if (ce) begin
      a_reg  <= din0;
      b_reg  <= din1;
      p_reg0 <= a_ext * b_ext;
      p_reg1 <= p_reg0;
    end
  end

  assign dout = p_reg1;
endmodule

// File: rtl/peg_bmtx_res_fifo.sv
// DEPTH-entry synchronous FIFO of tagged products with registered empty/full flags.
// Latency: a write is visible on rd_dat/empty the cycle after the write edge.
// Backpressure: none internally; the caller must never write when full.
module peg_bmtx_res_fifo
  import peg_bmtx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     wr_en,
  input  mul_res_t wr_dat,
  input  logic     rd_en,
  output mul_res_t rd_dat,
  output logic     empty,
  output logic     full
);
  localparam int AW = $clog2(DEPTH);

  mul_res_t      mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [AW:0]   wptr_nxt;
  logic [AW:0]   rptr_nxt;

  // Next pointer values; the extra MSB distinguishes full from empty.
  always_comb begin
    wptr_nxt = wptr + (AW+1)'(wr_en);
    rptr_nxt = rptr + (AW+1)'(rd_en);
  end

  // Storage array; no reset needed since entries are only read when flagged valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wr_dat;
  end

  // Pointers and flags registered from next-state so no flag depends combinationally on wr_en/rd_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      wptr  <= wptr_nxt;
      rptr  <= rptr_nxt;
      empty <= (wptr_nxt == rptr_nxt);
      full  <= (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]) && (wptr_nxt[AW] != rptr_nxt[AW]);
    end
  end

  assign rd_dat = mem[rptr[AW-1:0]];

  // Credit admission upstream makes an overflowing write impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(wr_en && full));
endmodule

// File: rtl/peg_bmtx_mul_stream.sv
// Ready/valid wrapper returning tagged 16s x 14u products in acceptance order.
// Latency: 4 cycles from acceptance edge to m_valid when the result FIFO is empty.
// Backpressure: credit counter holds s_ready low once DEPTH results are in flight; nothing is dropped.
module peg_bmtx_mul_stream
  import peg_bmtx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [A_W-1:0]   s_a,
  input  logic [B_W-1:0]          s_b,
  input  logic [TAG_W-1:0]        s_tag,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [P_W-1:0]   m_p,
  output logic [TAG_W-1:0]        m_tag,
  output logic                    idle
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]      cnt;
  logic               accept;
  logic               pop;
  logic [MUL_LAT-1:0] pipe_vld;
  logic [TAG_W-1:0]   pipe_tag [MUL_LAT];
  logic [P_W-1:0]     mul_p;
  mul_res_t           wr_res;
  mul_res_t           rd_res;
  logic               fifo_empty;
  logic               fifo_full;

  assign accept  = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  assign s_ready = (cnt < CW'(DEPTH));
  assign idle    = (cnt == '0);

  // Credit count: results accepted but not yet popped, whether in the pipe or the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Valid flags travel with the multiplier; clearing them on reset masks stale products.
  always_ff @(posedge clk) begin
    if (reset) pipe_vld <= '0;
    else       pipe_vld <= {pipe_vld[MUL_LAT-2:0], accept};
  end

  // Tags follow the same path as the valid flags.
  always_ff @(posedge clk) begin
    pipe_tag[0] <= s_tag;
    for (int i = 1; i < MUL_LAT; i++) pipe_tag[i] <= pipe_tag[i-1];
  end

  peg_bmtx_mul_mul_16s_14ns_30_4_1 #(
    .ID         (1),
    .NUM_STAGE  (4),
    .din0_WIDTH (A_W),
    .din1_WIDTH (B_W),
    .dout_WIDTH (P_W)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .ce    (1'b1),
    .din0  (s_a),
    .din1  (s_b),
    .dout  (mul_p)
  );

  assign wr_res.p   = mul_p;
  assign wr_res.tag = pipe_tag[MUL_LAT-1];

  peg_bmtx_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (pipe_vld[MUL_LAT-1]),
    .wr_dat (wr_res),
    .rd_en  (pop),
    .rd_dat (rd_res),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign m_valid = !fifo_empty;
  assign m_p     = rd_res.p;
  assign m_tag   = rd_res.tag;
endmodule

// File: tb/tb_peg_bmtx_mul_stream.sv
// Scoreboard bench for peg_bmtx_mul_stream: random and directed pairs against an arithmetic model.
// Latency: checks the 4-cycle acceptance-to-result timing and in-order delivery.
// Backpressure: exercises credit exhaustion, stalls, and reset discarding in-flight results.
module tb_peg_bmtx_mul_stream;
  logic               clk;
  logic               reset;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_a;
  logic [13:0]        s_b;
  logic [7:0]         s_tag;
  logic               m_valid;
  logic               m_ready;
  logic signed [29:0] m_p;
  logic [7:0]         m_tag;
  logic               idle;

  typedef struct {
    longint p;
    int     tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  peg_bmtx_mul_stream #(.DEPTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_a     (s_a),
    .s_b     (s_b),
    .s_tag   (s_tag),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_p     (m_p),
    .m_tag   (m_tag),
    .idle    (idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: model pushes on accepted pairs, compares on popped results, checks hold stability.
  logic               hold;
  logic signed [29:0] hold_p;
  logic [7:0]         hold_tag;
  initial hold = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      hold <= 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_p", m_p, hold_p);
        chk("hold_tag", m_tag, hold_tag);
      end
      if (s_valid && s_ready) begin
        exp_t e;
        e.p   = longint'(s_a) * longint'(s_b);
        e.tag = int'(s_tag);
        sb.push_back(e);
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result_p", m_p, e.p);
          chk("result_tag", m_tag, e.tag);
        end
      end
      hold     <= m_valid && !m_ready;
      hold_p   <= m_p;
      hold_tag <= m_tag;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one pair (called just after a rising edge) and return once it has been accepted.
  task automatic send(input logic signed [15:0] a, input logic [13:0] b, input logic [7:0] t);
    logic r;
    int   n;
    n = 0;
    s_a = a; s_b = b; s_tag = t; s_valid = 1'b1;
    forever begin
      @(negedge clk);
      r = s_ready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 100) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (idle && !m_valid && sb.size() == 0) break;
    end
    chk(nm, (n < 200), 1);
    step();
  endtask

  initial begin
    int idx;
    reset = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_tag = '0; m_ready = 1'b0;

    // 1: reset state
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_idle", idle, 1);
    end
    step();
    reset = 1'b0;
    m_ready = 1'b1;
    step();

    // 2: single pair latency
    send(-16'sd3, 14'd5, 8'd7);
    s_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t2_m_valid", m_valid, (k == 4));
    end
    step();

    // 3: extremes back-to-back, consecutive results
    send(-16'sd32768, 14'd16383, 8'd1);
    send(16'sd32767, 14'd16383, 8'd2);
    send(16'sd0, 14'd9, 8'd3);
    s_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t3_m_valid", m_valid, (k >= 2 && k <= 4));
    end
    step();
    wait_idle("t3_drain");

    // 4: credit exhaustion with m_ready low
    m_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      logic r;
      s_a = 16'($urandom); s_b = 14'($urandom); s_tag = 8'(idx); s_valid = 1'b1;
      @(negedge clk);
      r = s_ready;
      chk("t4_s_ready", r, (c < 8));
      step();
      if (r) idx++;
    end
    chk("t4_accepted", idx, 8);
    m_ready = 1'b1;
    while (idx < 10) begin
      send(16'($urandom), 14'($urandom), 8'(idx));
      idx++;
    end
    s_valid = 1'b0;
    wait_idle("t4_drain");

    // 5: 100 back-to-back random pairs at full rate
    m_ready = 1'b1;
    for (int i = 0; i < 105; i++) begin
      if (i < 100) begin
        s_a = 16'($urandom); s_b = 14'($urandom); s_tag = 8'($urandom); s_valid = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 100) chk("t5_s_ready", s_ready, 1);
      chk("t5_m_valid", m_valid, (i >= 4 && i < 104));
      chk("t5_idle", idle, (i == 0 || i >= 104));
      step();
    end
    s_valid = 1'b0;
    wait_idle("t5_drain");

    // 6: reset discards in-flight and buffered results
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(16'($urandom), 14'($urandom), 8'(100 + i));
    s_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t6_m_valid", m_valid, 0);
      chk("t6_s_ready", s_ready, 1);
      chk("t6_idle", idle, 1);
    end
    step();
    send(16'sd2, 14'd3, 8'd55);
    s_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t6_post_m_valid", m_valid, (k == 4));
      if (k == 4) chk("t6_post_p", m_p, 6);
    end
    step();
    wait_idle("t6_drain");

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
